// File: rtl/hack_memory.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hack_memory: Hack data memory map (RAM, screen, keyboard) plus display port
// Rev 1.0
// ----------------------------------------------------------------------------
module hack_memory #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_press,
  input  logic        kbd_release,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        bad_write
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  // Contents survive reset; only the simulation start value is defined.
  logic [15:0] r_ram [RAM_WORDS]    = '{default: 16'h0000};
  logic [15:0] r_scr [SCREEN_WORDS] = '{default: 16'h0000};

  logic [15:0] r_kbd;
  logic [15:0] r_scr_data;
  logic        r_bad;

  logic              w_sel_ram;
  logic              w_sel_scr;
  logic              w_sel_kbd;
  logic [31:0]       w_ram_off;
  logic [31:0]       w_scr_off;
  logic [31:0]       w_disp_off;
  logic              w_ram_ok;
  logic              w_scr_ok;
  logic              w_disp_ok;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [SCR_AW-1:0] w_scr_idx;
  logic [SCR_AW-1:0] w_disp_idx;
  logic              w_we_ram;
  logic              w_we_scr;

  assign w_sel_ram = ~addressM[14];
  assign w_sel_scr = (addressM[14:13] == 2'b10);
  assign w_sel_kbd = (addressM == 15'h6000);

  // Offsets widened so a shallower parameterised depth is range-checked, not wrapped.
  assign w_ram_off  = {18'd0, addressM[13:0]};
  assign w_scr_off  = {19'd0, addressM[12:0]};
  assign w_disp_off = {19'd0, scr_addr};

  assign w_ram_ok  = w_sel_ram && (w_ram_off < RAM_WORDS);
  assign w_scr_ok  = w_sel_scr && (w_scr_off < SCREEN_WORDS);
  assign w_disp_ok = (w_disp_off < SCREEN_WORDS);

  assign w_ram_idx  = addressM[RAM_AW-1:0];
  assign w_scr_idx  = addressM[SCR_AW-1:0];
  assign w_disp_idx = scr_addr[SCR_AW-1:0];

  assign w_we_ram = writeM & ~reset & w_ram_ok;
  assign w_we_scr = writeM & ~reset & w_scr_ok;

  always_comb begin
    inM = 16'h0000;
    if (w_ram_ok) begin
      inM = r_ram[w_ram_idx];
    end else if (w_scr_ok) begin
      inM = r_scr[w_scr_idx];
    end else if (w_sel_kbd) begin
      inM = r_kbd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we_ram) begin
      r_ram[w_ram_idx] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we_scr) begin
      r_scr[w_scr_idx] <= outM;
    end
  end

  // Non-blocking read returns the pre-edge word on a same-cycle CPU write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scr_data <= 16'h0000;
    end else if (w_disp_ok) begin
      r_scr_data <= r_scr[w_disp_idx];
    end else begin
      r_scr_data <= 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kbd <= 16'h0000;
    end else if (kbd_press) begin
      r_kbd <= kbd_code;
    end else if (kbd_release) begin
      r_kbd <= 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bad <= 1'b0;
    end else begin
      r_bad <= writeM & ~(w_sel_ram | w_sel_scr);
    end
  end

  assign scr_data  = r_scr_data;
  assign bad_write = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_hack_memory.sv
`default_nettype none
// tb_hack_memory: directed and randomized checks of hack_memory against a
// behavioural model of the memory map.
module tb_hack_memory;

  localparam int RW = 16384;
  localparam int SW = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] kbd_code;
  logic        kbd_press;
  logic        kbd_release;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        bad_write;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [15:0] m_ram [RW];
  logic [15:0] m_scr [SW];
  logic [15:0] m_kbd;
  logic [15:0] m_scr_data;
  logic        m_bad;

  hack_memory #(.RAM_WORDS(RW), .SCREEN_WORDS(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .addressM   (addressM),
    .outM       (outM),
    .writeM     (writeM),
    .inM        (inM),
    .kbd_code   (kbd_code),
    .kbd_press  (kbd_press),
    .kbd_release(kbd_release),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .bad_write  (bad_write)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] model_read(input logic [14:0] a);
    int ai;
    ai = int'(a);
    if (ai < 16'h4000) return m_ram[ai];
    if (ai < 16'h6000) return m_scr[ai - 16'h4000];
    if (ai == 16'h6000) return m_kbd;
    return 16'h0000;
  endfunction

  // Apply the effect of one rising edge, using the inputs currently driven.
  task automatic model_edge();
    int ai;
    ai = int'(addressM);
    if (reset) begin
      m_kbd      = 16'h0000;
      m_scr_data = 16'h0000;
      m_bad      = 1'b0;
    end else begin
      m_scr_data = (int'(scr_addr) < SW) ? m_scr[int'(scr_addr)] : 16'h0000;
      m_bad      = writeM && (ai >= 16'h6000);
      if (writeM && ai < 16'h4000) m_ram[ai] = outM;
      else if (writeM && ai < 16'h6000) m_scr[ai - 16'h4000] = outM;
      if (kbd_press) m_kbd = kbd_code;
      else if (kbd_release) m_kbd = 16'h0000;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    writeM      = 1'b0;
    kbd_press   = 1'b0;
    kbd_release = 1'b0;
    outM        = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    addressM = 15'h6000;
    kbd_code = 16'h0000;
    scr_addr = 13'h0000;
    tick();
    tick();
    total++;
    if (inM !== 16'h0000) begin
      bad++; $display("FAIL reset_kbd: got %h expected 0000", inM);
    end
    total++;
    if (scr_data !== 16'h0000) begin
      bad++; $display("FAIL reset_scr_data: got %h expected 0000", scr_data);
    end
    total++;
    if (bad_write !== 1'b0) begin
      bad++; $display("FAIL reset_bad_write: got %b expected 0", bad_write);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ram();
    addressM = 15'h0010; outM = 16'hBEEF; writeM = 1'b1;
    tick();
    idle_inputs();
    #1;
    total++;
    if (inM !== 16'hBEEF) begin
      bad++; $display("FAIL ram_readback: got %h expected BEEF", inM);
    end
    addressM = 15'h0011;
    #1;
    total++;
    if (inM !== 16'h0000) begin
      bad++; $display("FAIL ram_neighbour: got %h expected 0000", inM);
    end
    addressM = 15'h3FFF; outM = 16'hA5A5; writeM = 1'b1;
    tick();
    idle_inputs();
    addressM = 15'h4000;
    #1;
    total++;
    if (inM !== 16'h0000) begin
      bad++; $display("FAIL ram_top_no_wrap: got %h expected 0000", inM);
    end
  endtask

  task automatic test_screen();
    addressM = 15'h4005; outM = 16'h00FF; writeM = 1'b1;
    tick();
    idle_inputs();
    scr_addr = 13'h0005;
    tick();
    total++;
    if (scr_data !== 16'h00FF) begin
      bad++; $display("FAIL scr_read: got %h expected 00FF", scr_data);
    end
    addressM = 15'h4005; outM = 16'h1234; writeM = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (scr_data !== 16'h00FF) begin
      bad++; $display("FAIL scr_read_before_write: got %h expected 00FF", scr_data);
    end
    tick();
    total++;
    if (scr_data !== 16'h1234) begin
      bad++; $display("FAIL scr_new_word: got %h expected 1234", scr_data);
    end
    total++;
    if (inM !== 16'h1234) begin
      bad++; $display("FAIL scr_cpu_read: got %h expected 1234", inM);
    end
  endtask

  task automatic test_kbd();
    addressM = 15'h6000;
    kbd_code = 16'h0041; kbd_press = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (inM !== 16'h0041) begin
      bad++; $display("FAIL kbd_press: got %h expected 0041", inM);
    end
    tick();
    total++;
    if (inM !== 16'h0041) begin
      bad++; $display("FAIL kbd_hold: got %h expected 0041", inM);
    end
    kbd_release = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (inM !== 16'h0000) begin
      bad++; $display("FAIL kbd_release: got %h expected 0000", inM);
    end
    kbd_code = 16'h0080; kbd_press = 1'b1; kbd_release = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (inM !== 16'h0080) begin
      bad++; $display("FAIL kbd_press_wins: got %h expected 0080", inM);
    end
  endtask

  task automatic test_bad_write();
    addressM = 15'h6000; outM = 16'h5555; writeM = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (bad_write !== 1'b1) begin
      bad++; $display("FAIL bad_write_kbd: got %b expected 1", bad_write);
    end
    total++;
    if (inM !== 16'h0080) begin
      bad++; $display("FAIL kbd_unchanged: got %h expected 0080", inM);
    end
    tick();
    total++;
    if (bad_write !== 1'b0) begin
      bad++; $display("FAIL bad_write_one_cycle: got %b expected 0", bad_write);
    end
    addressM = 15'h7000; outM = 16'h5555; writeM = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (bad_write !== 1'b1) begin
      bad++; $display("FAIL bad_write_unmapped: got %b expected 1", bad_write);
    end
    total++;
    if (inM !== 16'h0000) begin
      bad++; $display("FAIL unmapped_read: got %h expected 0000", inM);
    end
    addressM = 15'h4005; outM = 16'h7777; writeM = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (bad_write !== 1'b0) begin
      bad++; $display("FAIL bad_write_legal: got %b expected 0", bad_write);
    end
    addressM = 15'h4005; outM = 16'h1234; writeM = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_blocking();
    kbd_code = 16'h0041; kbd_press = 1'b1; scr_addr = 13'h0005;
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    addressM = 15'h0020; outM = 16'h1111; writeM = 1'b1;
    kbd_code = 16'h0099; kbd_press = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    addressM = 15'h6000;
    #1;
    total++;
    if (inM !== 16'h0000) begin
      bad++; $display("FAIL reset_clears_kbd: got %h expected 0000", inM);
    end
    total++;
    if (scr_data !== 16'h0000) begin
      bad++; $display("FAIL reset_clears_scr_data: got %h expected 0000", scr_data);
    end
    addressM = 15'h0020;
    #1;
    total++;
    if (inM !== 16'h0000) begin
      bad++; $display("FAIL reset_blocks_write: got %h expected 0000", inM);
    end
    addressM = 15'h0010;
    #1;
    total++;
    if (inM !== 16'hBEEF) begin
      bad++; $display("FAIL reset_keeps_ram: got %h expected BEEF", inM);
    end
    addressM = 15'h4005;
    #1;
    total++;
    if (inM !== 16'h1234) begin
      bad++; $display("FAIL reset_keeps_screen: got %h expected 1234", inM);
    end
  endtask

  function automatic logic [14:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 15'($urandom_range(0, 31));
      1: return 15'($urandom_range(16'h3FF0, 16'h3FFF));
      2: return 15'($urandom_range(16'h4000, 16'h401F));
      3: return 15'($urandom_range(16'h5FF0, 16'h6000));
      default: return 15'($urandom_range(16'h6001, 16'h7FFF));
    endcase
  endfunction

  task automatic test_random();
    logic [15:0] exp_in;
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      addressM    = rand_addr();
      outM        = 16'($urandom);
      writeM      = ($urandom_range(0, 1) == 1);
      kbd_code    = 16'($urandom);
      kbd_press   = ($urandom_range(0, 3) == 0);
      kbd_release = ($urandom_range(0, 3) == 0);
      scr_addr    = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 31))
                                                : 13'($urandom_range(8176, 8191));
      #1;
      exp_in = model_read(addressM);
      total++;
      if (inM !== exp_in) begin
        bad++; $display("FAIL rand_inM[%0d] addr=%h: got %h expected %h", i, addressM, inM, exp_in);
      end
      tick();
      total++;
      if (scr_data !== m_scr_data) begin
        bad++; $display("FAIL rand_scr_data[%0d]: got %h expected %h", i, scr_data, m_scr_data);
      end
      total++;
      if (bad_write !== m_bad) begin
        bad++; $display("FAIL rand_bad_write[%0d]: got %b expected %b", i, bad_write, m_bad);
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < RW; i++) m_ram[i] = 16'h0000;
    for (int i = 0; i < SW; i++) m_scr[i] = 16'h0000;
    m_kbd = 16'h0000; m_scr_data = 16'h0000; m_bad = 1'b0;
    test_reset();
    test_ram();
    test_screen();
    test_kbd();
    test_bad_write();
    test_reset_blocking();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hack_memory.md
HACK_MEMORY -- requirements
Module: hack_memory

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 16384, giving the data RAM depth at 0x0000-0x3FFF.
REQ-002 The block SHALL have parameter SCREEN_WORDS, default 8192, giving the screen RAM depth at 0x4000-0x5FFF.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port addressM, input, 15 bits: CPU data address.
REQ-006 The block SHALL have port outM, input, 16 bits: CPU write data.
REQ-007 The block SHALL have port writeM, input, 1 bit: CPU write strobe.
REQ-008 The block SHALL have port inM, output, 16 bits: read data returned to the CPU.
REQ-009 The block SHALL have port kbd_code, input, 16 bits: key code from the keyboard front end.
REQ-010 The block SHALL have port kbd_press, input, 1 bit: single-cycle pulse marking a new key press.
REQ-011 The block SHALL have port kbd_release, input, 1 bit: single-cycle pulse marking a key release.
REQ-012 The block SHALL have port scr_addr, input, 13 bits: display-controller read address, word offset into the screen RAM.
REQ-013 The block SHALL have port scr_data, output, 16 bits: display read data, registered.
REQ-014 The block SHALL have port bad_write, output, 1 bit: registered single-cycle flag marking an illegal write.

Function
REQ-015 Address decode SHALL be:
- 0x0000-0x3FFF: RAM
- 0x4000-0x5FFF: SCREEN
- 0x6000: KBD
- 0x6001-0x7FFF: UNMAPPED
REQ-016 inM SHALL be combinational from addressM, the pre-edge contents, with zero wait states:
- RAM and SCREEN addresses: the word stored there
- KBD: the KBD register
- UNMAPPED: 0x0000
REQ-017 When writeM=1 and addressM is in RAM or SCREEN, outM SHALL be written to that word at the rising edge; inM at that address SHALL show the new value from the following cycle.
REQ-018 When writeM=1 and addressM is KBD or UNMAPPED, no storage SHALL change and bad_write SHALL be 1 for exactly the next cycle.
REQ-019 The KBD register SHALL update on each rising edge as follows:
- kbd_press=1: load kbd_code.
- kbd_release=1 with kbd_press=0: load 0x0000.
- kbd_press and kbd_release both 1: press wins.
- neither: hold.
REQ-020 scr_data SHALL hold the screen word at scr_addr one cycle after scr_addr is applied (latency 1), with no stall.
REQ-021 A CPU screen write and a display read of the same word in the same cycle SHALL return the old word on scr_data (read-before-write); the new word SHALL appear from the next read.
REQ-022 The CPU port and the display port SHALL operate independently every cycle; neither SHALL block the other.
REQ-023 scr_addr values at or above SCREEN_WORDS SHALL return 0x0000 on scr_data.
REQ-024 Width rules: addressM bits [12:0] SHALL index SCREEN after decode and bits [13:0] SHALL index RAM; there SHALL be no wrap-around into other regions.

Reset
REQ-025 While reset=1, at each rising edge: KBD SHALL be 0x0000, scr_data SHALL be 0x0000, bad_write SHALL be 0, and writes SHALL be suppressed.
REQ-026 RAM and SCREEN contents SHALL NOT be cleared by reset; their simulation initial value SHALL be 0x0000.
REQ-027 A reset asserted in the same cycle as writeM=1 SHALL block that write; a reset in the same cycle as kbd_press SHALL leave KBD at 0x0000.
REQ-028 Normal operation SHALL resume at the first edge with reset=0.

Verification
REQ-029 Write addressM=0x0010, outM=0xBEEF, writeM=1 for one cycle, then read 0x0010 -> inM=0xBEEF the next cycle; inM at 0x0011 stays 0x0000.
REQ-030 Write 0x4005=0x00FF, then scr_addr=0x0005 -> scr_data=0x00FF one cycle later; in a same-cycle rewrite to 0x1234 while reading -> scr_data=0x00FF, then 0x1234 on the next read.
REQ-031 kbd_code=0x0041 with a kbd_press pulse -> inM at 0x6000 = 0x0041; a kbd_release pulse -> 0x0000; press and release together with code 0x0080 -> 0x0080.
REQ-032 writeM=1 to 0x6000 with outM=0x5555 -> KBD unchanged and bad_write=1 for exactly one cycle; the same write to 0x7000 -> bad_write=1 and inM at 0x7000 = 0x0000.
REQ-033 With KBD=0x0041 and scr_data non-zero, assert reset together with writeM to 0x0020=0x1111 -> KBD=0x0000, scr_data=0x0000, word 0x0020 unchanged, and previously written RAM words retained.
